// File: rtl/spi_flash_sr_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_flash_sr_responder
// Description : SPI mode-0 target that emulates the status-register subset of
//               a SPI NOR flash (WREN/WRDI/WRSR/RDSR, optional SR2 commands).
//               All SPI pins are oversampled in the clk domain; clk must run at
//               least 4x faster than SCK.
// Config      : define SPI_RESP_SR2_EN to decode RDSR2 (35h) / WRSR2 (31h),
//               let the second WRSR byte update SR2 and keep SR2 as a live
//               register. Undefined: sr2 is tied to 8'h00 and has no flops.
// Ports       : clk, rst          - system clock, async active-high reset
//               spi_clk/mosi/cs_n - SPI inputs from the initiator (async)
//               spi_miso/_oe      - SPI data out and its drive enable
//               sr1, sr2          - current status registers (sr1[1] = WEL)
//               sr_wr_stb         - one-cycle pulse when a WRSR commits
// Revision    : 1.0 - initial release
// ============================================================================
module spi_flash_sr_responder #(
  parameter logic [7:0] SR1_INIT    = 8'h00,
  parameter logic [7:0] SR2_INIT    = 8'h00,
  parameter logic [7:0] SR1_WMASK   = 8'hFC,
  parameter logic [7:0] SR2_WMASK   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_clk,
  input  logic       spi_mosi,
  input  logic       spi_cs_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] sr1,
  output logic [7:0] sr2,
  output logic       sr_wr_stb
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CMD    = 3'd1,
    ST_WR     = 3'd2,
    ST_RD     = 3'd3,
    ST_IGNORE = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ACT_NONE  = 3'd0,
    ACT_WREN  = 3'd1,
    ACT_WRDI  = 3'd2,
    ACT_WRSR  = 3'd3,
    ACT_WRSR2 = 3'd4
  } act_t;

  // WIP (bit0) and WEL (bit1) are never touched by a status write.
  localparam logic [7:0] SR1_WMASK_EFF = SR1_WMASK & 8'hFC;
  localparam int         WEL           = 1;

  // ---------------------------------------------------------------------------
  // Input synchronisers and edge detection
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] csn_sync_q;
  logic                   sck_prev_q;
  logic                   csn_prev_q;

  // CS resets to "selected": if CS is already low when reset releases, no
  // false CS-fall is seen and the FSM waits for a genuine new frame. If CS is
  // high, the resulting CS-rise only returns an idle FSM to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      csn_sync_q  <= '0;
      sck_prev_q  <= 1'b0;
      csn_prev_q  <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_clk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
      csn_prev_q  <= csn_sync_q[SYNC_STAGES-1];
    end
  end

  logic w_sck_s, w_mosi_s, w_csn_s;
  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  assign w_sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign w_mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign w_csn_s    = csn_sync_q[SYNC_STAGES-1];
  assign w_sck_rise =  w_sck_s & ~sck_prev_q;
  assign w_sck_fall = ~w_sck_s &  sck_prev_q;
  assign w_cs_fall  = ~w_csn_s &  csn_prev_q;
  assign w_cs_rise  =  w_csn_s & ~csn_prev_q;

  // ---------------------------------------------------------------------------
  // Protocol state
  // ---------------------------------------------------------------------------
  state_t     state_q;
  act_t       act_q;       // action armed by the opcode of the current frame
  act_t       commit_q;    // action to apply on the cycle after CS-rise detect
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;  // data bytes captured in WR, saturating
  logic [6:0] shift_in_q;
  logic [7:0] b0_q;
  logic [7:0] rd_shift_q;
  logic [7:0] sr1_q;
  logic       miso_q;
  logic       oe_q;
  logic       stb_q;

  logic [7:0] w_rx_byte;
  logic [7:0] w_rd_live;
  logic [7:0] sr1_d;
  logic       stb_d;

  assign w_rx_byte = {shift_in_q, w_mosi_s};

`ifdef SPI_RESP_SR2_EN
  logic [7:0] sr2_q;
  logic [7:0] sr2_d;
  logic [7:0] b1_q;
  logic       rd_sel_q;   // 1: RD streams SR2
  assign w_rd_live = rd_sel_q ? sr2_q : sr1_q;
  assign sr2       = sr2_q;
`else
  logic w_sr2_params_unused;
  assign w_sr2_params_unused = ^{SR2_INIT, SR2_WMASK};
  assign w_rd_live = sr1_q;
  assign sr2       = 8'h00;
`endif

  // Commit of the previous frame. byte_cnt_q and the holding registers are
  // still intact here, even if a new CS-fall arrives in this same cycle.
  always_comb begin
    sr1_d = sr1_q;
    stb_d = 1'b0;
`ifdef SPI_RESP_SR2_EN
    sr2_d = sr2_q;
`endif
    case (commit_q)
      ACT_WREN: sr1_d[WEL] = 1'b1;
      ACT_WRDI: sr1_d[WEL] = 1'b0;
      ACT_WRSR: begin
        if (sr1_q[WEL] && (byte_cnt_q != 2'd0)) begin
          sr1_d = (sr1_q & ~SR1_WMASK_EFF) | (b0_q & SR1_WMASK_EFF);
`ifdef SPI_RESP_SR2_EN
          if (byte_cnt_q >= 2'd2) begin
            sr2_d = (sr2_q & ~SR2_WMASK) | (b1_q & SR2_WMASK);
          end
`endif
          sr1_d[WEL] = 1'b0;
          stb_d      = 1'b1;
        end
      end
`ifdef SPI_RESP_SR2_EN
      ACT_WRSR2: begin
        if (sr1_q[WEL] && (byte_cnt_q != 2'd0)) begin
          sr2_d      = (sr2_q & ~SR2_WMASK) | (b0_q & SR2_WMASK);
          sr1_d[WEL] = 1'b0;
          stb_d      = 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      act_q      <= ACT_NONE;
      commit_q   <= ACT_NONE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
      shift_in_q <= 7'd0;
      b0_q       <= 8'h00;
      rd_shift_q <= 8'h00;
      sr1_q      <= SR1_INIT & ~8'h02;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      stb_q      <= 1'b0;
`ifdef SPI_RESP_SR2_EN
      sr2_q      <= SR2_INIT;
      b1_q       <= 8'h00;
      rd_sel_q   <= 1'b0;
`endif
    end else begin
      sr1_q    <= sr1_d;
      stb_q    <= stb_d;
      commit_q <= ACT_NONE;
`ifdef SPI_RESP_SR2_EN
      sr2_q    <= sr2_d;
`endif
      if (w_cs_rise) begin
        // Only a byte-aligned frame may commit its action.
        state_q  <= ST_IDLE;
        oe_q     <= 1'b0;
        miso_q   <= 1'b0;
        commit_q <= (bit_cnt_q == 3'd0) ? act_q : ACT_NONE;
        act_q    <= ACT_NONE;
      end else if (w_cs_fall) begin
        state_q    <= ST_CMD;
        act_q      <= ACT_NONE;
        bit_cnt_q  <= 3'd0;
        byte_cnt_q <= 2'd0;
      end else begin
        if (w_sck_rise && (state_q != ST_IDLE)) begin
          bit_cnt_q  <= bit_cnt_q + 3'd1;
          shift_in_q <= w_rx_byte[6:0];
        end
        case (state_q)
          ST_CMD: begin
            if (w_sck_rise && (bit_cnt_q == 3'd7)) begin
              case (w_rx_byte)
                8'h06: begin act_q <= ACT_WREN; state_q <= ST_IGNORE; end
                8'h04: begin act_q <= ACT_WRDI; state_q <= ST_IGNORE; end
                8'h01: begin act_q <= ACT_WRSR; state_q <= ST_WR;     end
                8'h05: begin
                  rd_shift_q <= sr1_q;
                  state_q    <= ST_RD;
`ifdef SPI_RESP_SR2_EN
                  rd_sel_q   <= 1'b0;
`endif
                end
`ifdef SPI_RESP_SR2_EN
                8'h35: begin
                  rd_shift_q <= sr2_q;
                  rd_sel_q   <= 1'b1;
                  state_q    <= ST_RD;
                end
                8'h31: begin act_q <= ACT_WRSR2; state_q <= ST_WR; end
`endif
                default: state_q <= ST_IGNORE;
              endcase
            end
          end
          ST_WR: begin
            if (w_sck_rise && (bit_cnt_q == 3'd7)) begin
              if (byte_cnt_q == 2'd0) begin
                b0_q <= w_rx_byte;
              end
`ifdef SPI_RESP_SR2_EN
              if (byte_cnt_q == 2'd1) begin
                b1_q <= w_rx_byte;
              end
`endif
              if (byte_cnt_q != 2'd3) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
              end
            end
          end
          ST_RD: begin
            // bit_cnt_q at a fall equals the index of the bit being shifted
            // out, so 7 means the LSB is leaving: reload with the live value.
            if (w_sck_fall) begin
              oe_q   <= 1'b1;
              miso_q <= rd_shift_q[7];
              if (bit_cnt_q == 3'd7) begin
                rd_shift_q <= w_rd_live;
              end else begin
                rd_shift_q <= {rd_shift_q[6:0], 1'b0};
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign sr1         = sr1_q;
  assign sr_wr_stb   = stb_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_sr_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_flash_sr_responder
// Description : Self-checking bench for spi_flash_sr_responder. Directed flash
//               lock sequences followed by random SPI frames, checked against a
//               transaction-level model of the status registers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_flash_sr_responder;

  localparam int HALF = 8;  // clk cycles per SCK half period

  logic       clk = 1'b0;
  logic       rst;
  logic       spi_clk;
  logic       spi_mosi;
  logic       spi_cs_n;
  logic       spi_miso;
  logic       spi_miso_oe;
  logic [7:0] sr1;
  logic [7:0] sr2;
  logic       sr_wr_stb;

  spi_flash_sr_responder dut (
    .clk         (clk),
    .rst         (rst),
    .spi_clk     (spi_clk),
    .spi_mosi    (spi_mosi),
    .spi_cs_n    (spi_cs_n),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .sr1         (sr1),
    .sr2         (sr2),
    .sr_wr_stb   (sr_wr_stb)
  );

  always #5 clk = ~clk;

`ifdef SPI_RESP_SR2_EN
  localparam bit SR2_EN = 1'b1;
`else
  localparam bit SR2_EN = 1'b0;
`endif

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Strobe monitor: number of high cycles and back-to-back high cycles.
  int   stb_cnt  = 0;
  int   stb_long = 0;
  logic stb_prev = 1'b0;
  always @(negedge clk) begin
    if (sr_wr_stb === 1'b1) stb_cnt++;
    if (sr_wr_stb === 1'b1 && stb_prev === 1'b1) stb_long++;
    stb_prev = sr_wr_stb;
  end

  // Reference model of the flash status registers (sr1 bit1 = WEL).
  logic [7:0] m_sr1;
  logic [7:0] m_sr2;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    spi_mosi = b;
    wait_clk(HALF);
    spi_clk = 1'b1;
    wait_clk(HALF);
    spi_clk = 1'b0;
  endtask

  // One complete CS frame of nbits bits taken MSB-first from {c0,c1,c2,c3}.
  task automatic txn(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                     input logic [7:0] c3, input int nbits, input string tag);
    logic [31:0] tx;
    logic [7:0]  rxb;
    logic [7:0]  status;
    logic        exp_oe;
    bit          is_rd;
    bit          aligned;
    int          ndata;
    int          oe_bad;
    int          stb0;
    logic        exp_stb;
    tx      = {c0, c1, c2, c3};
    rxb     = 8'h00;
    is_rd   = (c0 == 8'h05) || (SR2_EN && c0 == 8'h35);
    status  = (c0 == 8'h35) ? m_sr2 : m_sr1;
    oe_bad  = 0;
    stb0    = stb_cnt;
    exp_stb = 1'b0;

    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[31-i];
      wait_clk(HALF);
      exp_oe = (is_rd && i >= 8);
      if (spi_miso_oe !== exp_oe) oe_bad++;
      rxb = {rxb[6:0], spi_miso};
      if (is_rd && i >= 8 && (i % 8) == 7) check_val({tag, ":rd_byte"}, rxb, status);
      spi_clk = 1'b1;
      wait_clk(HALF);
      spi_clk = 1'b0;
    end
    wait_clk(HALF);
    spi_cs_n = 1'b1;
    wait_clk(5);
    check_val({tag, ":oe_bits_wrong"}, oe_bad, 0);
    check_val({tag, ":oe_after_cs"}, spi_miso_oe, 1'b0);
    wait_clk(6);

    // Frame-level commit rules.
    aligned = (nbits >= 8) && ((nbits % 8) == 0);
    ndata   = nbits / 8 - 1;
    if (aligned) begin
      if (c0 == 8'h06) m_sr1[1] = 1'b1;
      else if (c0 == 8'h04) m_sr1[1] = 1'b0;
      else if (c0 == 8'h01 && m_sr1[1] && ndata >= 1) begin
        m_sr1 = (m_sr1 & 8'h03) | (c1 & 8'hFC);
        if (SR2_EN && ndata >= 2) m_sr2 = c2;
        m_sr1[1] = 1'b0;
        exp_stb  = 1'b1;
      end else if (SR2_EN && c0 == 8'h31 && m_sr1[1] && ndata >= 1) begin
        m_sr2    = c1;
        m_sr1[1] = 1'b0;
        exp_stb  = 1'b1;
      end
    end
    check_val({tag, ":stb"}, stb_cnt - stb0, {31'd0, exp_stb});
    check_val({tag, ":sr1"}, sr1, m_sr1);
    check_val({tag, ":sr2"}, sr2, SR2_EN ? m_sr2 : 8'h00);
  endtask

  initial begin
    logic [7:0] op;
    int         nb;
    rst      = 1'b1;
    spi_clk  = 1'b0;
    spi_mosi = 1'b0;
    spi_cs_n = 1'b1;
    m_sr1    = 8'h00;
    m_sr2    = 8'h00;
    wait_clk(4);
    check_val("rst_sr1", sr1, 8'h00);
    check_val("rst_oe", spi_miso_oe, 1'b0);
    rst = 1'b0;
    wait_clk(6);
    check_val("init_sr1", sr1, 8'h00);
    check_val("init_sr2", sr2, 8'h00);
    check_val("init_miso", spi_miso, 1'b0);
    check_val("init_oe", spi_miso_oe, 1'b0);
    check_val("init_stb", sr_wr_stb, 1'b0);

    // Directed lock sequences.
    txn(8'h05, 8'h00, 8'h00, 8'h00, 24, "rdsr_reset");
    txn(8'h06, 8'h00, 8'h00, 8'h00, 8,  "wren");
    txn(8'h05, 8'h00, 8'h00, 8'h00, 24, "rdsr_wel");
    txn(8'h04, 8'h00, 8'h00, 8'h00, 8,  "wrdi");
    txn(8'h01, 8'h3C, 8'h00, 8'h00, 16, "wrsr_no_wel");
    txn(8'h06, 8'h00, 8'h00, 8'h00, 8,  "wren2");
    txn(8'h01, 8'hFF, 8'h00, 8'h00, 16, "wrsr_ff");
    txn(8'h05, 8'h00, 8'h00, 8'h00, 16, "rdsr_fc");
    txn(8'h06, 8'h00, 8'h00, 8'h00, 8,  "wren3");
    txn(8'h01, 8'h1C, 8'h42, 8'h00, 24, "wrsr_2byte");
    txn(8'h35, 8'h00, 8'h00, 8'h00, 24, "rdsr2");
    txn(8'h06, 8'h00, 8'h00, 8'h00, 5,  "wren_abort");
    txn(8'h01, 8'h10, 8'h00, 8'h00, 16, "wrsr_after_abort");
    txn(8'h9F, 8'h00, 8'h00, 8'h00, 32, "rdid_unknown");
    txn(8'h06, 8'h00, 8'h00, 8'h00, 16, "wren_extra");
    txn(8'h01, 8'h00, 8'h00, 8'h00, 8,  "wrsr_no_data");
    txn(8'h01, 8'hA0, 8'h00, 8'h00, 13, "wrsr_misaligned");

    // Reset in the middle of a WRSR data byte.
    spi_cs_n = 1'b0;
    wait_clk(HALF);
    for (int i = 7; i >= 0; i--) send_bit(i == 0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rst = 1'b1;
    wait_clk(3);
    rst   = 1'b0;
    m_sr1 = 8'h00;
    m_sr2 = 8'h00;
    begin
      int s0;
      s0 = stb_cnt;
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      for (int i = 0; i < 8; i++) send_bit(1'b0);
      wait_clk(HALF);
      spi_cs_n = 1'b1;
      wait_clk(12);
      check_val("rst_mid:stb", stb_cnt - s0, 0);
      check_val("rst_mid:sr1", sr1, 8'h00);
      check_val("rst_mid:sr2", sr2, 8'h00);
    end
    txn(8'h05, 8'h00, 8'h00, 8'h00, 16, "rdsr_after_rst");

    // Random frames.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 7))
        0: op = 8'h06;
        1: op = 8'h04;
        2: op = 8'h01;
        3: op = 8'h05;
        4: op = 8'h35;
        5: op = 8'h31;
        6: op = 8'h9F;
        default: op = 8'($urandom);
      endcase
      if ((op == 8'h01 || op == 8'h31) && $urandom_range(0, 1) == 1)
        txn(8'h06, 8'h00, 8'h00, 8'h00, 8, "rnd_wren");
      nb = 8 * (1 + $urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) nb = nb - $urandom_range(1, 7);
      txn(op, 8'($urandom), 8'($urandom), 8'($urandom), nb, "rnd");
    end

    check_val("stb_width", stb_long, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
